seq_approx_divider: RTL



---
 rtl/seq_approx_divider_if.sv | 21 ++
 rtl/seq_approx_divider.sv | 130 +++++++++++++
 2 files changed

// File: rtl/seq_approx_divider_if.sv
// Start/ready/done handshake and operand/result bus for seq_approx_divider.
// The requester drives through master; the divider sits on slave.
interface seq_approx_divider_if #(
   parameter int W = 8
);
   logic             start;
   logic [2*W-1:0]   n;
   logic [W-1:0]     d;
   logic             approx_en;
   logic             ready;
   logic             done;
   logic [W-1:0]     q;
   logic [W-1:0]     r;
   logic             dz;
   logic             ovf;

   modport master (output start, n, d, approx_en,
                   input  ready, done, q, r, dz, ovf);
   modport slave  (input  start, n, d, approx_en,
                   output ready, done, q, r, dz, ovf);
endinterface

// File: rtl/seq_approx_divider.sv
// Restoring 2W/W divider, one quotient bit per clock, MSB first. The low
// APPROX_ROWS iterations can use an approximate borrow cell (approx_en).
module seq_approx_divider #(
   parameter int W           = 8,
   parameter int APPROX_ROWS = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_approx_divider_if.slave  bus
);
   localparam int          KW = (W > 1) ? $clog2(W) : 1;
   localparam logic [KW:0] AR = APPROX_ROWS[KW:0];

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [W:0]     p;
   logic [KW-1:0]  k;
   logic [W-1:0]   n_lo;
   logic [W-1:0]   d_r;
   logic           ae_r;
   logic           ovf_r;
   logic [W-1:0]   q_acc;

   logic           ready_q, done_q, dz_q, ovf_q;
   logic [W-1:0]   q_q, r_q;

   logic           row_approx;
   logic [W:0]     borrow;
   logic [W-1:0]   diff;
   logic           q_bit;
   logic [W-1:0]   r_nxt;
   logic [W-1:0]   q_nxt;

   assign row_approx = ae_r && ({1'b0, k} < AR);

   // Approximate cell drops the y/b dependence of the borrow chain,
   // so the final borrow collapses to ~P[W-1].
   always_comb begin
      borrow = '0;
      diff   = '0;
      for (int i = 0; i < W; i++) begin
         if (row_approx) begin
            diff[i]     = p[i] & ~borrow[i];
            borrow[i+1] = ~p[i];
         end else begin
            diff[i]     = p[i] ^ d_r[i] ^ borrow[i];
            borrow[i+1] = (~p[i] & d_r[i]) | (~(p[i] ^ d_r[i]) & borrow[i]);
         end
      end
   end

   always_comb begin
      q_bit    = p[W] | ~borrow[W];
      r_nxt    = q_bit ? diff : p[W-1:0];
      q_nxt    = q_acc;
      q_nxt[k] = q_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         p       <= '0;
         k       <= '0;
         n_lo    <= '0;
         d_r     <= '0;
         ae_r    <= 1'b0;
         ovf_r   <= 1'b0;
         q_acc   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  n_lo    <= bus.n[W-1:0];
                  d_r     <= bus.d;
                  ae_r    <= bus.approx_en;
                  ovf_r   <= (bus.n[2*W-1:W] >= bus.d);
                  ready_q <= 1'b0;
                  if (bus.d == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     q_q    <= '1;
                     r_q    <= bus.n[W-1:0];
                     dz_q   <= 1'b1;
                     ovf_q  <= (bus.n[2*W-1:W] >= bus.d);
                  end else begin
                     p     <= bus.n[2*W-1:W-1];
                     k     <= KW'(W-1);
                     q_acc <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               q_acc <= q_nxt;
               if (k == '0) begin
                  q_q    <= q_nxt;
                  r_q    <= r_nxt;
                  dz_q   <= 1'b0;
                  ovf_q  <= ovf_r;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  p <= {r_nxt, n_lo[k - 1'b1]};
                  k <= k - 1'b1;
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.q     = q_q;
   assign bus.r     = r_q;
   assign bus.dz    = dz_q;
   assign bus.ovf   = ovf_q;
endmodule
